// File: rtl/set_bit_scanner_if.sv
// rtl/set_bit_scanner_if.sv - load/position handshake bundle for set_bit_scanner
// Master side offers vectors and consumes indices; slave side is the scanner.
interface set_bit_scanner_if #(
  parameter int N     = 10,
  parameter int POS_W = $clog2(N)
);
  logic             load_valid;
  logic             load_ready;
  logic [N-1:0]     load_data;
  logic             flush;
  logic             pos_valid;
  logic             pos_ready;
  logic [POS_W-1:0] pos_out;
  logic             pos_last;
  logic             done;

  modport master (
    output load_valid, load_data, flush, pos_ready,
    input  load_ready, pos_valid, pos_out, pos_last, done
  );

  modport slave (
    input  load_valid, load_data, flush, pos_ready,
    output load_ready, pos_valid, pos_out, pos_last, done
  );
endinterface

// File: rtl/set_bit_scanner.sv
// rtl/set_bit_scanner.sv - emits indices of set bits of a loaded vector, lowest first
// One index per accepted handshake; flush/rst abandon the scan without a done pulse.
module set_bit_scanner #(
  parameter int  N     = 10,
  localparam int POS_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  set_bit_scanner_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     remaining_q, remaining_d;
  logic             done_q, done_d;

  logic [N-1:0]     rem_minus1;
  logic [N-1:0]     lowest_bit;
  logic [N-1:0]     rem_cleared;
  logic [POS_W-1:0] lowest_idx;
  logic             is_last;

  // Isolate the lowest set bit (r & ~(r-1)) and one-hot encode it.
  always_comb begin
    rem_minus1  = remaining_q - N'(1);
    lowest_bit  = remaining_q & ~rem_minus1;
    rem_cleared = remaining_q & rem_minus1;
    is_last     = (rem_cleared == '0);
    lowest_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (lowest_bit[i]) begin
        lowest_idx = lowest_idx | POS_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    if (bus.flush) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            remaining_d = bus.load_data;
            if (bus.load_data != '0) begin
              state_d = EMIT;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.pos_ready) begin
            remaining_d = rem_cleared;
            if (is_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE);
    bus.pos_valid  = (state_q == EMIT);
    bus.pos_out    = (state_q == EMIT) ? lowest_idx : '0;
    bus.pos_last   = (state_q == EMIT) && is_last;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_set_bit_scanner.sv
// tb/tb_set_bit_scanner.sv - randomized self-checking bench for set_bit_scanner
// Expected index streams come from a per-bit walk of the loaded vector.
module tb_set_bit_scanner;
  localparam int N     = 10;
  localparam int POS_W = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  set_bit_scanner_if #(.N(N)) bus ();
  set_bit_scanner #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.flush      = 1'b0;
    bus.pos_ready  = 1'b0;
  endtask

  // Snapshot {pos_valid, pos_out, pos_last, done, load_ready}
  function automatic logic [POS_W+3:0] snap();
    return {bus.pos_valid, bus.pos_out, bus.pos_last, bus.done, bus.load_ready};
  endfunction

  task automatic test_reset();
    logic [POS_W+3:0] got;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=%h", got, {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1});
    end
    rst = 1'b0;
    @(negedge clk);
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_idle got=%h", got);
    end
  endtask

  // mode 0: pos_ready always 1, 1: random, 2: pattern bits LSB first
  task automatic run_scan(input logic [N-1:0] vec, input int mode, input logic [31:0] pat,
                          input bit junk, input string tag);
    int exp_q[$];
    int k;
    int cyc = 0;
    logic rdy;
    logic [POS_W+3:0] got, exp;
    for (int i = 0; i < N; i++) if (vec[i]) exp_q.push_back(i);
    k = exp_q.size();

    @(negedge clk);
    total++;
    if (bus.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s load_ready_before got=%b exp=1", tag, bus.load_ready);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = vec;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_data  = '0;

    while (exp_q.size() > 0 && cyc < 4 * N + 20) begin
      got = snap();
      exp = {1'b1, POS_W'(exp_q[0]), exp_q.size() == 1, 1'b0, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s emit cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc < 32) ? pat[cyc] : 1'b1;
      endcase
      bus.pos_ready = rdy;
      if (junk) begin
        bus.load_valid = 1'b1;
        bus.load_data  = ($urandom_range(0, 1) == 1) ? N'(1) : N'($urandom);
      end
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      if (rdy) void'(exp_q.pop_front());
      cyc++;
    end
    bus.pos_ready = 1'b0;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout left=%0d exp=0", tag, exp_q.size());
    end
    if (mode == 0) begin
      total++;
      if (cyc != k) begin
        bad++;
        $display("FAIL %s throughput cycles=%0d exp=%0d", tag, cyc, k);
      end
    end
    if (mode == 2) begin
      total++;
      if (cyc != 5) begin
        bad++;
        $display("FAIL %s pattern_cycles got=%0d exp=5", tag, cyc);
      end
    end
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL %s done_pulse got=%h exp=%h", tag, got, {1'b0, {POS_W{1'b0}}, 1'b0, 1'b1, 1'b1});
    end
    @(negedge clk);
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s done_single got=%h exp=%h", tag, got, {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_directed();
    run_scan(10'b1000100110, 0, 32'h0, 1'b0, "sparse");
    run_scan(10'b1111111111, 0, 32'h0, 1'b0, "full");
    run_scan(10'b0000010001, 2, 32'hFFFF_FFF4, 1'b0, "backpressure");
    run_scan(10'b0000000000, 0, 32'h0, 1'b0, "empty");
    run_scan(10'b1000000000, 0, 32'h0, 1'b0, "top_bit");
  endtask

  task automatic test_ignore_load();
    run_scan(10'b0101100100, 0, 32'h0, 1'b1, "ignore_load");
    run_scan(10'b1100000011, 1, 32'h0, 1'b1, "ignore_load_rnd");
  endtask

  task automatic test_abort(input bit use_rst, input string tag);
    logic [POS_W+3:0] got;
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_data  = 10'b0110000000;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    got = snap();
    total++;
    if (got !== {1'b1, POS_W'(7), 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s first_idx got=%h exp=%h", tag, got, {1'b1, POS_W'(7), 1'b0, 1'b0, 1'b0});
    end
    bus.pos_ready = 1'b1;
    @(negedge clk);
    got = snap();
    total++;
    if (got !== {1'b1, POS_W'(8), 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s second_idx got=%h exp=%h", tag, got, {1'b1, POS_W'(8), 1'b1, 1'b0, 1'b0});
    end
    if (use_rst) rst = 1'b1;
    else bus.flush = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 10'b0000001011;
    @(negedge clk);
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.pos_ready  = 1'b0;
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s after_abort got=%h exp=%h", tag, got, {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1});
    end
    @(negedge clk);
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s no_done_no_capture got=%h", tag, got);
    end
  endtask

  task automatic test_flush_idle();
    logic [POS_W+3:0] got;
    @(negedge clk);
    bus.flush      = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = '1;
    @(negedge clk);
    bus.flush      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    got = snap();
    total++;
    if (got !== {1'b0, {POS_W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL flush_idle_blocks_load got=%h", got);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] vec;
    int sel;
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 7);
      if (sel == 0) vec = '0;
      else if (sel == 1) vec = '1;
      else vec = N'($urandom);
      run_scan(vec, ($urandom_range(0, 1) == 1) ? 1 : 0, 32'h0, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_scan(10'b0000000011, 0, 32'h0, 1'b0, "b2b_a");
    run_scan(10'b0000000000, 0, 32'h0, 1'b0, "b2b_b");
    run_scan(10'b1010101010, 1, 32'h0, 1'b0, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_load();
    test_abort(1'b0, "flush");
    run_scan(10'b0000100001, 0, 32'h0, 1'b0, "after_flush");
    test_abort(1'b1, "rst");
    run_scan(10'b0001000100, 0, 32'h0, 1'b0, "after_rst");
    test_flush_idle();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
